// File: rtl/mem_arbiter_pkg.sv
// Shared bus definitions for the memory arbiter.
//   arb_state_t     : arbiter FSM states (IDLE, ISSUE, RESP).
//   req_id_t        : requester identity (IF = 0, DR = 1, DW = 2).
//   TIMEOUT_DEFAULT : default number of ISSUE cycles to wait for mem_ack.
//   grant_to_id / id_to_onehot : conversions between one-hot grants and ids.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        IF = 2'd0,
        DR = 2'd1,
        DW = 2'd2
    } req_id_t;

    localparam int TIMEOUT_DEFAULT = 255;

    function automatic req_id_t grant_to_id(input logic [2:0] grant);
        req_id_t id;
        case (grant)
            3'b001:  id = IF;
            3'b010:  id = DR;
            3'b100:  id = DW;
            default: id = IF;
        endcase
        return id;
    endfunction

    function automatic logic [2:0] id_to_onehot(input req_id_t id);
        logic [2:0] oh;
        case (id)
            IF:      oh = 3'b001;
            DR:      oh = 3'b010;
            DW:      oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage : mem_arbiter_pkg

// File: rtl/pipeline_pkg.sv
// Pipeline-wide constants shared by every block on the core side.
//   XLEN : architectural address/data width.
package pipeline_pkg;

    localparam int XLEN = 32;

endpackage : pipeline_pkg

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational rotating-priority winner selection.
//   req   [2:0] : request vector, bit index = requester id.
//   ptr         : id of the last winner; the search starts just after it.
//   grant [2:0] : one-hot grant, all zero when nothing is requested.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic    [2:0] req,
    input  req_id_t       ptr,
    output logic    [2:0] grant
);

    // Search order is ptr+1, ptr+2, ptr (mod 3), so the last winner is served last.
    always_comb begin
        grant = 3'b000;
        case (ptr)
            IF: begin
                if (req[1])      grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else             grant = 3'b000;
            end
            DR: begin
                if (req[2])      grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else             grant = 3'b000;
            end
            DW: begin
                if (req[0])      grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else             grant = 3'b000;
            end
            default: grant = 3'b000;
        endcase
    end

endmodule : arb_pick

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (if),
// data read (dr) and data write (dw) requesters.
//   Optional feature macro ARB_RR_EN: round-robin arbitration over
//   {if, dr, dw}; without it, fixed priority dw > dr > if with no pointer.
// Ports:
//   clk, reset                  : clock and synchronous active-high reset.
//   if_req/if_addr/if_ack       : fetch request, address, completion pulse.
//   dr_req/dr_addr/dr_ack       : data read request, address, completion pulse.
//   dw_req/dw_addr/dw_wdata/dw_wstrb/dw_ack : data write request and pulse.
//   rsp_rdata, rsp_err          : response data / timeout flag, valid with an ack.
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb : shared memory request.
//   mem_ack, mem_rdata          : memory completion and read data.
//   busy                        : high while a transaction is in ISSUE or RESP.
// All outputs are registered.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int XLEN    = pipeline_pkg::XLEN,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [XLEN-1:0]     if_addr,
    output logic                if_ack,
    input  logic                dr_req,
    input  logic [XLEN-1:0]     dr_addr,
    output logic                dr_ack,
    input  logic                dw_req,
    input  logic [XLEN-1:0]     dw_addr,
    input  logic [XLEN-1:0]     dw_wdata,
    input  logic [XLEN/8-1:0]   dw_wstrb,
    output logic                dw_ack,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic                rsp_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    input  logic                mem_ack,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                busy
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    arb_state_t        state_r, state_s;
    req_id_t           id_r, id_s;
    logic [7:0]        cnt_r, cnt_s;
    logic              mem_req_r, mem_req_s;
    logic              mem_we_r, mem_we_s;
    logic [XLEN-1:0]   mem_addr_r, mem_addr_s;
    logic [XLEN-1:0]   mem_wdata_r, mem_wdata_s;
    logic [XLEN/8-1:0] mem_wstrb_r, mem_wstrb_s;
    logic [XLEN-1:0]   rsp_rdata_r, rsp_rdata_s;
    logic              rsp_err_r, rsp_err_s;
    logic [2:0]        ack_r, ack_s;
    logic              busy_r, busy_s;

    logic [2:0]        req_vec_s;
    logic [2:0]        pick_req_s;
    logic [2:0]        pick_grant_s;
    logic [2:0]        grant_s;
    req_id_t           pick_ptr_s;
    req_id_t           win_id_s;

    assign req_vec_s = {dw_req, dr_req, if_req};

`ifdef ARB_RR_EN
    req_id_t ptr_r, ptr_s;

    assign pick_req_s = req_vec_s;
    assign pick_ptr_s = ptr_r;
    assign grant_s    = pick_grant_s;
`else
    // Fixed dw > dr > if is obtained from the rotating picker by reversing
    // the request order and parking the pointer on the last slot.
    assign pick_req_s = {req_vec_s[0], req_vec_s[1], req_vec_s[2]};
    assign pick_ptr_s = DW;
    assign grant_s    = {pick_grant_s[0], pick_grant_s[1], pick_grant_s[2]};
`endif

    arb_pick u_arb_pick (
        .req   (pick_req_s),
        .ptr   (pick_ptr_s),
        .grant (pick_grant_s)
    );

    assign win_id_s = grant_to_id(grant_s);

    // Next-state and next-output computation for the arbiter FSM.
    always_comb begin
        state_s     = state_r;
        id_s        = id_r;
        cnt_s       = cnt_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        mem_wstrb_s = mem_wstrb_r;
        rsp_rdata_s = rsp_rdata_r;
        rsp_err_s   = rsp_err_r;
        ack_s       = 3'b000;
        busy_s      = busy_r;
`ifdef ARB_RR_EN
        ptr_s       = ptr_r;
`endif
        case (state_r)
            IDLE: begin
                if (|req_vec_s) begin
                    state_s   = ISSUE;
                    id_s      = win_id_s;
                    cnt_s     = 8'd0;
                    mem_req_s = 1'b1;
                    busy_s    = 1'b1;
`ifdef ARB_RR_EN
                    ptr_s     = win_id_s;
`endif
                    case (win_id_s)
                        DW: begin
                            mem_we_s    = 1'b1;
                            mem_addr_s  = dw_addr;
                            mem_wdata_s = dw_wdata;
                            mem_wstrb_s = dw_wstrb;
                        end
                        DR: begin
                            mem_we_s    = 1'b0;
                            mem_addr_s  = dr_addr;
                            mem_wdata_s = {XLEN{1'b0}};
                            mem_wstrb_s = {(XLEN/8){1'b0}};
                        end
                        default: begin
                            mem_we_s    = 1'b0;
                            mem_addr_s  = if_addr;
                            mem_wdata_s = {XLEN{1'b0}};
                            mem_wstrb_s = {(XLEN/8){1'b0}};
                        end
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                // mem_ack is checked first so it wins over a coincident expiry.
                if (mem_ack) begin
                    state_s     = RESP;
                    mem_req_s   = 1'b0;
                    rsp_rdata_s = mem_we_r ? {XLEN{1'b0}} : mem_rdata;
                    rsp_err_s   = 1'b0;
                    ack_s       = id_to_onehot(id_r);
                end else if ((cnt_r + 8'd1) == TIMEOUT_C) begin
                    state_s     = RESP;
                    cnt_s       = cnt_r + 8'd1;
                    mem_req_s   = 1'b0;
                    rsp_rdata_s = {XLEN{1'b0}};
                    rsp_err_s   = 1'b1;
                    ack_s       = id_to_onehot(id_r);
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            RESP: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s   = IDLE;
                mem_req_s = 1'b0;
                busy_s    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            id_r        <= IF;
            cnt_r       <= 8'd0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {XLEN{1'b0}};
            mem_wdata_r <= {XLEN{1'b0}};
            mem_wstrb_r <= {(XLEN/8){1'b0}};
            rsp_rdata_r <= {XLEN{1'b0}};
            rsp_err_r   <= 1'b0;
            ack_r       <= 3'b000;
            busy_r      <= 1'b0;
`ifdef ARB_RR_EN
            ptr_r       <= DW;
`endif
        end else begin
            state_r     <= state_s;
            id_r        <= id_s;
            cnt_r       <= cnt_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            mem_wstrb_r <= mem_wstrb_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_err_r   <= rsp_err_s;
            ack_r       <= ack_s;
            busy_r      <= busy_s;
`ifdef ARB_RR_EN
            ptr_r       <= ptr_s;
`endif
        end
    end

    assign if_ack    = ack_r[0];
    assign dr_ack    = ack_r[1];
    assign dw_ack    = ack_r[2];
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_wstrb = mem_wstrb_r;
    assign busy      = busy_r;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (TIMEOUT = 4). Honours ARB_RR_EN
// in its reference model so the same file covers both arbitration modes.
module tb_mem_arbiter;

    localparam int XLEN = 32;
    localparam int TO   = 4;

    logic              clk;
    logic              reset;
    logic              if_req, dr_req, dw_req;
    logic [XLEN-1:0]   if_addr, dr_addr, dw_addr, dw_wdata;
    logic [XLEN/8-1:0] dw_wstrb;
    logic              if_ack, dr_ack, dw_ack;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;
    logic              mem_req, mem_we;
    logic [XLEN-1:0]   mem_addr, mem_wdata;
    logic [XLEN/8-1:0] mem_wstrb;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_rdata;
    logic              busy;

    int checks   = 0;
    int failures = 0;
    int model_last = 2;

    mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .dr_req(dr_req), .dr_addr(dr_addr), .dr_ack(dr_ack),
        .dw_req(dw_req), .dw_addr(dw_addr), .dw_wdata(dw_wdata),
        .dw_wstrb(dw_wstrb), .dw_ack(dw_ack),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: id of the requester that should win, -1 if none.
    function automatic int model_pick(input logic [2:0] r);
        int pick;
        pick = -1;
`ifdef ARB_RR_EN
        // Walk last+1, last+2, last+3 (mod 3); first requester in that order wins.
        for (int k = 3; k >= 1; k--) begin
            if (r[(model_last + k) % 3]) pick = (model_last + k) % 3;
        end
`else
        // Highest id wins (dw > dr > if).
        for (int i = 0; i < 3; i++) begin
            if (r[i]) pick = i;
        end
`endif
        return pick;
    endfunction

    task automatic raise(input int id);
        case (id)
            0: begin if_req = 1'b1; if_addr = XLEN'($urandom()); end
            1: begin dr_req = 1'b1; dr_addr = XLEN'($urandom()); end
            default: begin
                dw_req   = 1'b1;
                dw_addr  = XLEN'($urandom());
                dw_wdata = XLEN'($urandom());
                dw_wstrb = 4'($urandom_range(1, 15));
            end
        endcase
    endtask

    task automatic drop_all();
        if_req = 1'b0; dr_req = 1'b0; dw_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; drop_all(); mem_ack = 1'b0;
        tick();
        reset = 1'b0;
        model_last = 2;
    endtask

    // One full transaction from IDLE: latch, ISSUE with ack after lat cycles
    // (lat >= TO means no ack), RESP, back to IDLE. obs = id seen on the acks.
    task automatic run_txn(input int lat, input logic [XLEN-1:0] rdata,
                           input bit drop, input string name, output int obs);
        int w;
        logic [XLEN-1:0]   exp_addr, exp_rd;
        logic [XLEN/8-1:0] exp_strb;
        logic              exp_err;
        w = model_pick({dw_req, dr_req, if_req});
        case (w)
            2:       exp_addr = dw_addr;
            1:       exp_addr = dr_addr;
            default: exp_addr = if_addr;
        endcase
        exp_strb = (w == 2) ? dw_wstrb : 4'h0;
        tick();
        checks++;
        if ({mem_req, busy, mem_we} !== {1'b1, 1'b1, (w == 2)}) begin
            failures++;
            $display("FAIL %s issue_ctrl got req/busy/we=%b%b%b exp=11%b", name, mem_req, busy, mem_we, (w == 2));
        end
        checks++;
        if (mem_addr !== exp_addr || mem_wstrb !== exp_strb) begin
            failures++;
            $display("FAIL %s issue_addr got %h/%h exp %h/%h", name, mem_addr, mem_wstrb, exp_addr, exp_strb);
        end
        if (w == 2) begin
            checks++;
            if (mem_wdata !== dw_wdata) begin
                failures++;
                $display("FAIL %s issue_wdata got %h exp %h", name, mem_wdata, dw_wdata);
            end
        end
        for (int k = 1; k <= TO; k++) begin
            mem_ack   = (k == lat + 1);
            mem_rdata = (k == lat + 1) ? rdata : XLEN'($urandom());
            tick();
            mem_ack = 1'b0;
            if (k == lat + 1 || k == TO) break;
            checks++;
            if ({mem_req, dw_ack, dr_ack, if_ack} !== 4'b1000 || mem_addr !== exp_addr) begin
                failures++;
                $display("FAIL %s wait_cycle%0d got req=%b acks=%b%b%b addr=%h exp req=1 acks=000 addr=%h",
                         name, k, mem_req, dw_ack, dr_ack, if_ack, mem_addr, exp_addr);
            end
        end
        exp_err = (lat >= TO);
        exp_rd  = (exp_err || w == 2) ? '0 : rdata;
        obs = dw_ack ? 2 : (dr_ack ? 1 : (if_ack ? 0 : -1));
        checks++;
        if ({dw_ack, dr_ack, if_ack} !== (3'b001 << w)) begin
            failures++;
            $display("FAIL %s resp_ack got %b exp %b", name, {dw_ack, dr_ack, if_ack}, (3'b001 << w));
        end
        checks++;
        if (rsp_rdata !== exp_rd || rsp_err !== exp_err) begin
            failures++;
            $display("FAIL %s resp_data got %h err=%b exp %h err=%b", name, rsp_rdata, rsp_err, exp_rd, exp_err);
        end
        checks++;
        if ({mem_req, busy} !== 2'b01) begin
            failures++;
            $display("FAIL %s resp_ctrl got req/busy=%b%b exp 01", name, mem_req, busy);
        end
        model_last = w;
        if (drop) begin
            case (w)
                2:       dw_req = 1'b0;
                1:       dr_req = 1'b0;
                default: if_req = 1'b0;
            endcase
        end
        tick();
        checks++;
        if ({dw_ack, dr_ack, if_ack, busy, mem_req} !== 5'b00000) begin
            failures++;
            $display("FAIL %s idle got acks=%b busy=%b req=%b exp all 0", name, {dw_ack, dr_ack, if_ack}, busy, mem_req);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if_req = 1'b1; dr_req = 1'b1; dw_req = 1'b1; mem_ack = 1'b1;
        if_addr = XLEN'($urandom()); dr_addr = XLEN'($urandom());
        dw_addr = XLEN'($urandom()); dw_wdata = XLEN'($urandom()); dw_wstrb = 4'hF;
        mem_rdata = XLEN'($urandom());
        tick();
        checks++;
        if ({if_ack, dr_ack, dw_ack, rsp_err, mem_req, mem_we, busy} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got %b exp 0000000", {if_ack, dr_ack, dw_ack, rsp_err, mem_req, mem_we, busy});
        end
        checks++;
        if (rsp_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0 || mem_wstrb !== '0) begin
            failures++;
            $display("FAIL reset_data got rdata=%h addr=%h wdata=%h strb=%h exp 0", rsp_rdata, mem_addr, mem_wdata, mem_wstrb);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        int obs;
        if_req = 1'b1; if_addr = 32'h0000_0100;
        run_txn(0, 32'hDEAD_BEEF, 1'b1, "single_read", obs);
    endtask

    task automatic test_priority();
        int obs;
`ifdef ARB_RR_EN
        int exp_order [3] = '{0, 1, 2};
`else
        int exp_order [3] = '{2, 1, 0};
`endif
        do_reset();
        raise(0); raise(1); raise(2);
        for (int i = 0; i < 3; i++) begin
            run_txn(i, XLEN'($urandom()), 1'b1, "priority", obs);
            checks++;
            if (obs !== exp_order[i]) begin
                failures++;
                $display("FAIL priority_order step%0d got id %0d exp %0d", i, obs, exp_order[i]);
            end
        end
    endtask

    task automatic test_held_requests();
        int obs;
`ifdef ARB_RR_EN
        int exp_order [6] = '{0, 1, 2, 0, 1, 2};
`else
        int exp_order [6] = '{2, 2, 2, 2, 2, 2};
`endif
        do_reset();
        raise(0); raise(1); raise(2);
        for (int i = 0; i < 6; i++) begin
            run_txn(0, XLEN'($urandom()), 1'b0, "held", obs);
            checks++;
            if (obs !== exp_order[i]) begin
                failures++;
                $display("FAIL held_order step%0d got id %0d exp %0d", i, obs, exp_order[i]);
            end
        end
        drop_all();
        tick();
    endtask

    task automatic test_timeout();
        int obs;
        dw_req = 1'b1; dw_addr = 32'h0000_2000; dw_wdata = 32'h1234_5678; dw_wstrb = 4'h3;
        run_txn(99, 32'hFFFF_FFFF, 1'b1, "timeout_write", obs);
        dr_req = 1'b1; dr_addr = 32'h0000_3000;
        run_txn(TO - 1, 32'hCAFE_F00D, 1'b1, "ack_on_expiry", obs);
        if_req = 1'b1; if_addr = 32'h0000_4000;
        run_txn(99, 32'h5555_AAAA, 1'b1, "timeout_read", obs);
    endtask

    task automatic test_reset_mid_issue();
        int obs;
        dr_req = 1'b1; dr_addr = 32'h0000_5000;
        tick();
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL midreset_issue got mem_req=%b exp 1", mem_req);
        end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({mem_req, busy, dw_ack, dr_ack, if_ack} !== 5'b00000) begin
            failures++;
            $display("FAIL midreset_abandon got req=%b busy=%b acks=%b exp all 0", mem_req, busy, {dw_ack, dr_ack, if_ack});
        end
        reset = 1'b0; drop_all(); model_last = 2;
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({mem_req, busy, dw_ack, dr_ack, if_ack} !== 5'b00000) begin
                failures++;
                $display("FAIL late_ack cycle%0d got req=%b busy=%b acks=%b exp all 0", i, mem_req, busy, {dw_ack, dr_ack, if_ack});
            end
            tick();
        end
        // The arbitration pointer must be back at its reset position.
        raise(0); raise(1); raise(2);
        run_txn(0, XLEN'($urandom()), 1'b1, "post_reset_pick", obs);
        drop_all();
        tick();
    endtask

    task automatic test_random();
        int obs;
        logic [2:0] cur;
        for (int n = 0; n < 40; n++) begin
            cur = {dw_req, dr_req, if_req};
            for (int id = 0; id < 3; id++) begin
                if (!cur[id] && ($urandom_range(0, 1) == 1)) raise(id);
            end
            if ({dw_req, dr_req, if_req} == 3'b000) raise(int'($urandom_range(0, 2)));
            run_txn(int'($urandom_range(0, 5)), XLEN'($urandom()), 1'b1, "random", obs);
        end
        drop_all();
        tick();
    endtask

    initial begin
        reset = 1'b1; mem_ack = 1'b0; drop_all();
        if_addr = '0; dr_addr = '0; dw_addr = '0; dw_wdata = '0; dw_wstrb = '0; mem_rdata = '0;
        test_reset();
        test_single_read();
        test_priority();
        test_held_requests();
        test_timeout();
        test_reset_mid_issue();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_arbiter
